// File: rtl/cpu_types_pkg.sv
// Shared types for the CPU memory path: data word, RAM handshake state and
// the instruction/data memory arbiter state encoding.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE,
        DACC,
        IACC,
        SCFAIL
    } arb_state_t;

endpackage

// File: rtl/llsc_link.sv
// Load-linked reservation: remembers the address of the last LL and reports
// whether the current data address still holds a valid reservation.
module llsc_link
    import cpu_types_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_set,
    input  logic  i_clear,
    input  word_t i_addr,
    output logic  o_valid,
    output logic  o_match
);

    logic  r_valid;
    word_t r_addr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_set) begin
            r_valid <= 1'b1;
            r_addr  <= i_addr;
        end
    end

    assign o_valid = r_valid;
    assign o_match = r_valid && (r_addr == i_addr);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data load/store onto one RAM port, with
// LL/SC reservation tracking, alternating fairness and a sticky stall timeout.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  logic      dLL,
    input  logic      dSC,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      timeout
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    arb_state_t      r_state, w_state_nxt;
    logic            r_last_d, w_last_d_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_timeout, w_timeout_set;

    logic w_dreq;
    logic w_d_done;
    logic w_i_done;
    logic w_expire;
    logic w_sc_fail;
    logic w_link_set;
    logic w_link_clear;
    logic w_link_valid;
    logic w_link_match;

    assign w_dreq    = dREN | dWEN;
    assign w_d_done  = (r_state == DACC) && w_dreq && (ramstate == ACCESS);
    assign w_i_done  = (r_state == IACC) && iREN && (ramstate == ACCESS);
    assign w_expire  = (ramstate == ERROR) || (r_cnt == CW'(MAX_WAIT - 1));
    assign w_sc_fail = dWEN && dSC && !(w_link_valid && w_link_match);

    // Only completed D accesses touch the reservation; a plain store snoops it.
    assign w_link_set   = w_d_done && dREN && dLL;
    assign w_link_clear = (w_d_done && dWEN && (dSC || w_link_match)) || (r_state == SCFAIL);

    llsc_link u_link (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_set   (w_link_set),
        .i_clear (w_link_clear),
        .i_addr  (daddr),
        .o_valid (w_link_valid),
        .o_match (w_link_match)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= IDLE;
            r_last_d  <= 1'b0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_last_d <= w_last_d_nxt;
            r_cnt    <= w_cnt_nxt;
            if (w_timeout_set) begin
                r_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_last_d_nxt  = r_last_d;
        w_timeout_set = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_last_d && iREN) begin
                    w_state_nxt  = IACC;
                    w_last_d_nxt = 1'b0;
                end else if (w_dreq) begin
                    w_state_nxt  = w_sc_fail ? SCFAIL : DACC;
                    w_last_d_nxt = 1'b1;
                end else if (iREN) begin
                    w_state_nxt  = IACC;
                    w_last_d_nxt = 1'b0;
                end
            end
            DACC: begin
                if (!w_dreq || ramstate == ACCESS) begin
                    w_state_nxt = IDLE;
                end else if (w_expire) begin
                    w_state_nxt   = IDLE;
                    w_timeout_set = 1'b1;
                end
            end
            IACC: begin
                if (!iREN || ramstate == ACCESS) begin
                    w_state_nxt = IDLE;
                end else if (w_expire) begin
                    w_state_nxt   = IDLE;
                    w_timeout_set = 1'b1;
                end
            end
            SCFAIL:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Stall counter runs only while an access is held without progress.
    always_comb begin
        w_cnt_nxt = '0;
        if ((w_state_nxt == r_state) && (r_state == DACC || r_state == IACC)) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        dload    = ramload;
        unique case (r_state)
            DACC: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (dWEN && dSC) begin
                    dload = 32'd1;
                end
            end
            IACC: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
            end
            SCFAIL:  dload = '0;
            default: ;
        endcase
    end

    assign iwait   = iREN && !w_i_done;
    assign dwait   = w_dreq && !w_d_done && (r_state != SCFAIL);
    assign iload   = ramload;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: fetch, fairness, LL/SC,
// abort, timeout, error and asynchronous reset scenarios.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic      CLK = 1'b0;
    logic      RST;
    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;
    logic      dREN, dWEN, dLL, dSC;
    word_t     daddr, dstore;
    logic      dwait;
    word_t     dload;
    logic      ramREN, ramWEN;
    word_t     ramaddr, ramstore, ramload;
    ramstate_t ramstate;
    logic      timeout;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_count = 0;

    mem_arbiter #(.MAX_WAIT(16)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .dLL      (dLL),
        .dSC      (dSC),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .timeout  (timeout)
    );

    always #5 CLK = ~CLK;

    // Completed RAM writes, sampled mid-cycle.
    always @(negedge CLK) begin
        if (ramWEN && ramstate == ACCESS) wr_count <= wr_count + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drop_all();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; dLL = 1'b0; dSC = 1'b0;
        ramstate = FREE;
    endtask

    // Issues one D access from IDLE and samples outputs in its ACCESS cycle.
    task automatic d_op(input logic ren, input logic wen, input logic ll, input logic sc,
                        input word_t addr, input word_t store, input int busy,
                        input word_t rdata, output logic o_dwait, output word_t o_dload,
                        output logic o_wen, output word_t o_store);
        dREN = ren; dWEN = wen; dLL = ll; dSC = sc; daddr = addr; dstore = store;
        ramstate = FREE;
        tick();
        repeat (busy) begin
            ramstate = BUSY;
            tick();
        end
        ramstate = ACCESS;
        ramload  = rdata;
        @(negedge CLK);
        o_dwait = dwait; o_dload = dload; o_wen = ramWEN; o_store = ramstore;
        tick();
        drop_all();
    endtask

    task automatic test_reset();
        RST = 1'b1; iREN = 1'b1; dREN = 1'b1;
        repeat (2) @(negedge CLK);
        n_tests++;
        if (iwait !== 1'b1) begin n_fail++; $display("FAIL rst_iwait: got %b want 1", iwait); end
        n_tests++;
        if (dwait !== 1'b1) begin n_fail++; $display("FAIL rst_dwait: got %b want 1", dwait); end
        n_tests++;
        if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin
            n_fail++; $display("FAIL rst_ramctl: got %b%b want 00", ramREN, ramWEN);
        end
        n_tests++;
        if (timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %b want 0", timeout); end
        drop_all();
        #1;
        n_tests++;
        if (iwait !== 1'b0) begin n_fail++; $display("FAIL rst_iwait_low: got %b want 0", iwait); end
        tick();
        RST = 1'b0;
        tick();
        n_tests++;
        if (dut.r_state !== IDLE) begin
            n_fail++; $display("FAIL rst_state: got %0d want %0d", dut.r_state, IDLE);
        end
    endtask

    task automatic test_fetch();
        iREN = 1'b1; iaddr = 32'h40; ramstate = FREE;
        tick();
        n_tests++;
        if (dut.r_state !== IACC) begin
            n_fail++; $display("FAIL fetch_grant: got %0d want %0d", dut.r_state, IACC);
        end
        for (int i = 0; i < 2; i++) begin
            ramstate = BUSY;
            @(negedge CLK);
            n_tests++;
            if (iwait !== 1'b1 || ramREN !== 1'b1 || ramaddr !== 32'h40) begin
                n_fail++;
                $display("FAIL fetch_busy%0d: got iwait=%b ren=%b addr=%h want 1 1 00000040",
                         i, iwait, ramREN, ramaddr);
            end
            tick();
        end
        ramstate = ACCESS; ramload = 32'hDEADBEEF;
        @(negedge CLK);
        n_tests++;
        if (iwait !== 1'b0) begin n_fail++; $display("FAIL fetch_iwait: got %b want 0", iwait); end
        n_tests++;
        if (iload !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL fetch_iload: got %h want deadbeef", iload);
        end
        tick();
        n_tests++;
        if (dut.r_state !== IDLE) begin
            n_fail++; $display("FAIL fetch_done: got %0d want %0d", dut.r_state, IDLE);
        end
        drop_all();
    endtask

    task automatic test_fairness();
        iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h200; ramstate = FREE;
        tick();
        n_tests++;
        if (dut.r_state !== DACC) begin
            n_fail++; $display("FAIL fair_d_first: got %0d want %0d", dut.r_state, DACC);
        end
        ramstate = ACCESS; ramload = 32'h1234;
        @(negedge CLK);
        n_tests++;
        if (dwait !== 1'b0 || iwait !== 1'b1) begin
            n_fail++; $display("FAIL fair_d_done: got dwait=%b iwait=%b want 0 1", dwait, iwait);
        end
        tick();
        ramstate = FREE;
        tick();
        n_tests++;
        if (dut.r_state !== IACC) begin
            n_fail++; $display("FAIL fair_i_next: got %0d want %0d", dut.r_state, IACC);
        end
        ramstate = ACCESS; ramload = 32'h5678;
        @(negedge CLK);
        n_tests++;
        if (iwait !== 1'b0 || dwait !== 1'b1 || iload !== 32'h5678) begin
            n_fail++;
            $display("FAIL fair_i_done: got iwait=%b dwait=%b iload=%h want 0 1 00005678",
                     iwait, dwait, iload);
        end
        tick();
        drop_all();
        tick();
    endtask

    task automatic test_llsc();
        logic  w;
        logic  we;
        word_t ld;
        word_t st;
        int    wr0;
        d_op(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1, 32'hAAAA, w, ld, we, st);
        n_tests++;
        if (w !== 1'b0 || ld !== 32'hAAAA) begin
            n_fail++; $display("FAIL ll_load: got dwait=%b dload=%h want 0 0000aaaa", w, ld);
        end
        n_tests++;
        if (dut.u_link.r_valid !== 1'b1) begin
            n_fail++; $display("FAIL ll_link: got %b want 1", dut.u_link.r_valid);
        end
        wr0 = wr_count;
        d_op(1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h5, 0, 32'h0, w, ld, we, st);
        n_tests++;
        if (w !== 1'b0 || ld !== 32'd1 || we !== 1'b1 || st !== 32'h5) begin
            n_fail++;
            $display("FAIL sc_ok: got dwait=%b dload=%h wen=%b store=%h want 0 1 1 5",
                     w, ld, we, st);
        end
        n_tests++;
        if (wr_count !== wr0 + 1) begin
            n_fail++; $display("FAIL sc_writes: got %0d want %0d", wr_count - wr0, 1);
        end
        dWEN = 1'b1; dSC = 1'b1; daddr = 32'h100; dstore = 32'h5;
        tick();
        n_tests++;
        if (dut.r_state !== SCFAIL) begin
            n_fail++; $display("FAIL sc2_state: got %0d want %0d", dut.r_state, SCFAIL);
        end
        @(negedge CLK);
        n_tests++;
        if (dwait !== 1'b0 || dload !== 32'd0 || ramWEN !== 1'b0) begin
            n_fail++;
            $display("FAIL sc2_fail: got dwait=%b dload=%h wen=%b want 0 0 0", dwait, dload, ramWEN);
        end
        tick();
        drop_all();
        n_tests++;
        if (dut.r_state !== IDLE || wr_count !== wr0 + 1) begin
            n_fail++;
            $display("FAIL sc2_after: got state=%0d writes=%0d want %0d 1",
                     dut.r_state, wr_count - wr0, IDLE);
        end
    endtask

    task automatic test_store_clears();
        logic  w;
        logic  we;
        word_t ld;
        word_t st;
        d_op(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 0, 32'h0, w, ld, we, st);
        d_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h7, 1, 32'h0, w, ld, we, st);
        n_tests++;
        if (dut.u_link.r_valid !== 1'b0 || we !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_clear: got link=%b wen=%b want 0 1", dut.u_link.r_valid, we);
        end
        dWEN = 1'b1; dSC = 1'b1; daddr = 32'h100; dstore = 32'h9;
        tick();
        @(negedge CLK);
        n_tests++;
        if (dut.r_state !== SCFAIL || dload !== 32'd0) begin
            n_fail++;
            $display("FAIL sw_sc: got state=%0d dload=%h want %0d 0", dut.r_state, dload, SCFAIL);
        end
        tick();
        drop_all();
    endtask

    task automatic test_abort();
        dREN = 1'b1; dLL = 1'b1; daddr = 32'h300;
        tick();
        dREN = 1'b0; dLL = 1'b0; ramstate = ACCESS;
        tick();
        n_tests++;
        if (dut.r_state !== IDLE || dut.u_link.r_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: got state=%0d link=%b want %0d 0",
                     dut.r_state, dut.u_link.r_valid, IDLE);
        end
        drop_all();
    endtask

    task automatic test_timeout();
        dREN = 1'b1; daddr = 32'h400; ramstate = BUSY;
        tick();
        repeat (15) tick();
        n_tests++;
        if (dut.r_state !== DACC || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL to_before: got state=%0d timeout=%b want %0d 0",
                     dut.r_state, timeout, DACC);
        end
        tick();
        n_tests++;
        if (dut.r_state !== IDLE || timeout !== 1'b1 || dwait !== 1'b1) begin
            n_fail++;
            $display("FAIL to_fire: got state=%0d timeout=%b dwait=%b want %0d 1 1",
                     dut.r_state, timeout, dwait, IDLE);
        end
        drop_all();
        repeat (3) tick();
        n_tests++;
        if (timeout !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want 1", timeout); end
    endtask

    task automatic test_reset_mid();
        logic  w;
        logic  we;
        word_t ld;
        word_t st;
        d_op(1'b1, 1'b0, 1'b1, 1'b0, 32'h500, 32'h0, 0, 32'h0, w, ld, we, st);
        dREN = 1'b1; daddr = 32'h600; ramstate = BUSY;
        tick();
        @(negedge CLK);
        n_tests++;
        if (ramREN !== 1'b1 || dut.u_link.r_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_pre: got ren=%b link=%b want 1 1", ramREN, dut.u_link.r_valid);
        end
        #1 RST = 1'b1;
        #1;
        n_tests++;
        if (ramREN !== 1'b0 || ramWEN !== 1'b0 || dut.r_state !== IDLE) begin
            n_fail++;
            $display("FAIL rm_drop: got ren=%b wen=%b state=%0d want 0 0 %0d",
                     ramREN, ramWEN, dut.r_state, IDLE);
        end
        n_tests++;
        if (dut.u_link.r_valid !== 1'b0 || timeout !== 1'b0 || dwait !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_clear: got link=%b timeout=%b dwait=%b want 0 0 1",
                     dut.u_link.r_valid, timeout, dwait);
        end
        tick();
        RST = 1'b0;
        drop_all();
        tick();
    endtask

    task automatic test_error();
        iREN = 1'b1; iaddr = 32'h80;
        tick();
        ramstate = ERROR;
        @(negedge CLK);
        n_tests++;
        if (iwait !== 1'b1 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL err_pre: got iwait=%b timeout=%b want 1 0", iwait, timeout);
        end
        tick();
        n_tests++;
        if (dut.r_state !== IDLE || timeout !== 1'b1 || iwait !== 1'b1) begin
            n_fail++;
            $display("FAIL err_fire: got state=%0d timeout=%b iwait=%b want %0d 1 1",
                     dut.r_state, timeout, iwait, IDLE);
        end
        drop_all();
        tick();
    endtask

    initial begin
        RST = 1'b1;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
        drop_all();
        test_reset();
        test_fetch();
        test_fairness();
        test_llsc();
        test_store_clears();
        test_abort();
        test_timeout();
        test_reset_mid();
        test_error();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
